mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single main-memory block port between the instruction-cache controller (read-only) and the data-cache controller (block read and block write-back). Sits between both cache controllers and the memory model; holds a grant for one whole memory transaction, forwards the memory handshake only to the granted requester, and resolves ties round-robin.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory block-port bundle shared by the I-cache, D-cache and memory sides of mem_port_arbiter.
// slave = arbiter view, master = requester/memory (testbench) view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
);
  logic               i_memRen;
  logic [ADDR_W-1:0]  i_BlockAddr;
  logic               i_memReadReady;
  logic [BLOCK_W-1:0] i_memDout;

  logic               d_memRen;
  logic               d_memWen;
  logic [ADDR_W-1:0]  d_BlockAddr;
  logic [BLOCK_W-1:0] d_memDin;
  logic               d_memReadReady;
  logic               d_memWriteDone;
  logic [BLOCK_W-1:0] d_memDout;

  logic               memRen;
  logic               memWen;
  logic [ADDR_W-1:0]  memAddr;
  logic [BLOCK_W-1:0] memDin;
  logic [BLOCK_W-1:0] memDout;
  logic               memReadReady;
  logic               memWriteDone;

  logic [1:0]         grant;

  modport slave (
    input  i_memRen, i_BlockAddr, d_memRen, d_memWen, d_BlockAddr, d_memDin,
           memDout, memReadReady, memWriteDone,
    output i_memReadReady, i_memDout, d_memReadReady, d_memWriteDone, d_memDout,
           memRen, memWen, memAddr, memDin, grant
  );

  modport master (
    output i_memRen, i_BlockAddr, d_memRen, d_memWen, d_BlockAddr, d_memDin,
           memDout, memReadReady, memWriteDone,
    input  i_memReadReady, i_memDout, d_memReadReady, d_memWriteDone, d_memDout,
           memRen, memWen, memAddr, memDin, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory block port between I-cache (read) and D-cache (read/write-back), one grant per transaction.
// MEM_ARB_DPRIO_EN: fixed D priority on ties; otherwise round-robin via the r_last flag.
module mem_port_arbiter (
  input logic            clock,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e r_state;
  state_e w_next_state;
  logic   w_i_req;
  logic   w_d_req;

  assign w_i_req = bus.i_memRen;
  assign w_d_req = bus.d_memRen | bus.d_memWen;

`ifndef MEM_ARB_DPRIO_EN
  logic r_last;
`endif

  // Next state: a grant lasts until completion or until the requester drops its request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
`ifdef MEM_ARB_DPRIO_EN
          w_next_state = GNT_D;
`else
          w_next_state = r_last ? GNT_I : GNT_D;
`endif
        end else if (w_i_req) begin
          w_next_state = GNT_I;
        end else if (w_d_req) begin
          w_next_state = GNT_D;
        end
      end
      GNT_I: if (bus.memReadReady || !w_i_req) w_next_state = IDLE;
      GNT_D: if (bus.memReadReady || bus.memWriteDone || !w_d_req) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
`ifndef MEM_ARB_DPRIO_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_next_state;
`ifndef MEM_ARB_DPRIO_EN
      if (r_state == IDLE && w_next_state != IDLE) r_last <= (w_next_state == GNT_D);
`endif
    end
  end

  // Port steering is combinational from state so completions forward with zero latency.
  always_comb begin
    bus.memRen         = 1'b0;
    bus.memWen         = 1'b0;
    bus.memAddr        = '0;
    bus.memDin         = '0;
    bus.i_memReadReady = 1'b0;
    bus.i_memDout      = '0;
    bus.d_memReadReady = 1'b0;
    bus.d_memWriteDone = 1'b0;
    bus.d_memDout      = '0;
    bus.grant          = r_state;
    case (r_state)
      GNT_I: begin
        bus.memRen         = bus.i_memRen;
        bus.memAddr        = bus.i_BlockAddr;
        bus.i_memReadReady = bus.memReadReady;
        bus.i_memDout      = bus.memDout;
      end
      GNT_D: begin
        bus.memAddr        = bus.d_BlockAddr;
        bus.memDin         = bus.d_memDin;
        bus.memWen         = bus.d_memWen;
        bus.memRen         = bus.d_memRen & ~bus.d_memWen;
        bus.d_memReadReady = bus.memReadReady;
        bus.d_memWriteDone = bus.memWriteDone;
        bus.d_memDout      = bus.memDout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; define MEM_ARB_DPRIO_EN to check fixed-priority mode.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned BLOCK_W = 128;
  localparam logic [BLOCK_W-1:0] DATA_A5 = {16{8'hA5}};
  localparam logic [BLOCK_W-1:0] DATA_5A = {16{8'h5A}};
  localparam logic [BLOCK_W-1:0] DATA_WR = {8{16'h1234}};

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  mem_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_memRen     = 1'b0;
    bus.i_BlockAddr  = '0;
    bus.d_memRen     = 1'b0;
    bus.d_memWen     = 1'b0;
    bus.d_BlockAddr  = '0;
    bus.d_memDin     = '0;
    bus.memDout      = '0;
    bus.memReadReady = 1'b0;
    bus.memWriteDone = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
    checks++; if ({bus.memRen, bus.memWen} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {bus.memRen, bus.memWen}); end
    checks++; if (bus.memAddr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.memAddr); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_i_read();
    bus.i_memRen    = 1'b1;
    bus.i_BlockAddr = 28'h0000010;
    #1;
    checks++; if (bus.memRen !== 1'b0) begin errors++; $display("FAIL iread_idle_ren got=%b exp=0", bus.memRen); end
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL iread_grant got=%b exp=01", bus.grant); end
    checks++; if (bus.memAddr !== 28'h0000010) begin errors++; $display("FAIL iread_addr got=%h exp=0000010", bus.memAddr); end
    checks++; if ({bus.memRen, bus.memWen} !== 2'b10) begin errors++; $display("FAIL iread_strobes got=%b exp=10", {bus.memRen, bus.memWen}); end
    tick();
    bus.memReadReady = 1'b1;
    bus.memDout      = DATA_A5;
    #1;
    checks++; if (bus.i_memReadReady !== 1'b1) begin errors++; $display("FAIL iread_ready got=%b exp=1", bus.i_memReadReady); end
    checks++; if (bus.i_memDout !== DATA_A5) begin errors++; $display("FAIL iread_dout got=%h exp=%h", bus.i_memDout, DATA_A5); end
    checks++; if (bus.d_memReadReady !== 1'b0) begin errors++; $display("FAIL iread_dready got=%b exp=0", bus.d_memReadReady); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL iread_release got=%b exp=00", bus.grant); end
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.i_memRen    = 1'b1;
    bus.i_BlockAddr = 28'h0000020;
    bus.d_memRen    = 1'b1;
    bus.d_BlockAddr = 28'h0000030;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL rr_first got=%b exp=01", bus.grant); end
    checks++; if (bus.memAddr !== 28'h0000020) begin errors++; $display("FAIL rr_first_addr got=%h exp=0000020", bus.memAddr); end
    bus.memReadReady = 1'b1;
    bus.memDout      = DATA_A5;
    #1;
    checks++; if (bus.i_memReadReady !== 1'b1) begin errors++; $display("FAIL rr_i_ready got=%b exp=1", bus.i_memReadReady); end
    tick();
    bus.memReadReady = 1'b0;
    #1;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rr_gap1 got=%b exp=00", bus.grant); end
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL rr_second got=%b exp=10", bus.grant); end
    checks++; if (bus.memAddr !== 28'h0000030) begin errors++; $display("FAIL rr_second_addr got=%h exp=0000030", bus.memAddr); end
    bus.memReadReady = 1'b1;
    bus.memDout      = DATA_5A;
    #1;
    checks++; if (bus.d_memReadReady !== 1'b1 || bus.d_memDout !== DATA_5A) begin errors++; $display("FAIL rr_d_ready got=%b/%h exp=1/%h", bus.d_memReadReady, bus.d_memDout, DATA_5A); end
    checks++; if (bus.i_memReadReady !== 1'b0 || bus.i_memDout !== '0) begin errors++; $display("FAIL rr_i_quiet got=%b/%h exp=0/0", bus.i_memReadReady, bus.i_memDout); end
    tick();
    bus.memReadReady = 1'b0;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL rr_third got=%b exp=01", bus.grant); end
    bus.memReadReady = 1'b1;
    tick();
    clear_inputs();
    tick();
    bus.i_memRen = 1'b1;
    bus.d_memRen = 1'b1;
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL rr_alternate got=%b exp=10", bus.grant); end
    bus.memReadReady = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_dprio();
    apply_reset();
    bus.i_memRen = 1'b1;
    bus.d_memRen = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL dprio_grant%0d got=%b exp=10", t, bus.grant); end
      bus.memReadReady = 1'b1;
      #1;
      checks++; if (bus.i_memReadReady !== 1'b0) begin errors++; $display("FAIL dprio_i_ready%0d got=%b exp=0", t, bus.i_memReadReady); end
      tick();
      bus.memReadReady = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    bus.d_memWen    = 1'b1;
    bus.d_memRen    = 1'b1;
    bus.d_memDin    = DATA_WR;
    bus.d_BlockAddr = 28'h00000FF;
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL wr_grant got=%b exp=10", bus.grant); end
    checks++; if ({bus.memRen, bus.memWen} !== 2'b01) begin errors++; $display("FAIL wr_strobes got=%b exp=01", {bus.memRen, bus.memWen}); end
    checks++; if (bus.memDin !== DATA_WR || bus.memAddr !== 28'h00000FF) begin errors++; $display("FAIL wr_data got=%h/%h exp=%h/00000ff", bus.memDin, bus.memAddr, DATA_WR); end
    bus.memWriteDone = 1'b1;
    #1;
    checks++; if ({bus.d_memWriteDone, bus.d_memReadReady} !== 2'b10) begin errors++; $display("FAIL wr_done got=%b exp=10", {bus.d_memWriteDone, bus.d_memReadReady}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.grant !== 2'b00 || bus.memWen !== 1'b0) begin errors++; $display("FAIL wr_release got=%b/%b exp=00/0", bus.grant, bus.memWen); end
    tick();
  endtask

  task automatic test_abort();
    bus.i_memRen    = 1'b1;
    bus.i_BlockAddr = 28'h0000040;
    tick();
    checks++; if (bus.memRen !== 1'b1) begin errors++; $display("FAIL abort_ren got=%b exp=1", bus.memRen); end
    bus.i_memRen = 1'b0;
    #1;
    checks++; if (bus.memRen !== 1'b0) begin errors++; $display("FAIL abort_drop got=%b exp=0", bus.memRen); end
    tick();
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL abort_idle got=%b exp=00", bus.grant); end
  endtask

  task automatic test_reset_mid();
    bus.i_memRen    = 1'b1;
    bus.i_BlockAddr = 28'h0000050;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL rstmid_grant got=%b exp=01", bus.grant); end
    reset = 1'b0;
    #1;
    checks++; if (bus.grant !== 2'b00 || bus.memRen !== 1'b0 || bus.memAddr !== '0) begin errors++; $display("FAIL rstmid_async got=%b/%b/%h exp=00/0/0", bus.grant, bus.memRen, bus.memAddr); end
    bus.i_memRen = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rstmid_idle got=%b exp=00", bus.grant); end
    bus.memReadReady = 1'b1;
    bus.memDout      = DATA_A5;
    #1;
    checks++; if (bus.i_memReadReady !== 1'b0 || bus.i_memDout !== '0) begin errors++; $display("FAIL rstmid_late got=%b/%h exp=0/0", bus.i_memReadReady, bus.i_memDout); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rstmid_stay got=%b exp=00", bus.grant); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_i_read();
`ifdef MEM_ARB_DPRIO_EN
    test_dprio();
`else
    test_round_robin();
`endif
    test_write();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
